// File: rtl/pwm_output_stage.sv
// PWM output stage: prescaler, 8-bit period counter and per-pin enable/PWM mux.
// Optional PWM_SHADOW_EN: duty is latched once per period at the wrap tick.
module pwm_output_stage #(
  parameter int unsigned CLK_DIV = 13,
  parameter int unsigned PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0] presc_cnt;
  logic [7:0]         pwm_cnt;
  logic [7:0]         duty_active;
  logic               tick;
  logic               wrap;
  logic               pwm_lvl;
  logic [15:0]        en_out;
  logic [15:0]        en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign tick   = (presc_cnt == PRESC_MAX);
  assign wrap   = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

`ifdef PWM_SHADOW_EN
  always_ff @(posedge clk) begin
    if (rst)       duty_active <= '0;
    else if (wrap) duty_active <= pwm_duty_cycle;
  end
`else
  assign duty_active = pwm_duty_cycle;
`endif

  // 0xFF is forced high so the full-scale setting never drops for the count 255
  always_comb begin
    pwm_lvl = 1'b0;
    if (duty_active == 8'hFF) pwm_lvl = 1'b1;
    else                      pwm_lvl = (pwm_cnt < duty_active);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= en_out & (~en_pwm | {16{pwm_lvl}});
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench for pwm_output_stage: cycle-index reference model feeding a
// scoreboard queue, a vector table, and hand sequences for period-level corner cases.
module tb_pwm_output_stage;

  localparam int unsigned CD = 3;
  localparam int P = 256 * CD;
`ifdef PWM_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;

  pwm_output_stage #(.CLK_DIV(CD), .PRESC_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] o;
    logic        ps;
    string       tag;
  } exp_t;

  typedef struct {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  d;
    int          cycles;
    string       name;
  } vec_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          m_n = 0;
  logic [7:0]  m_shadow = '0;
  logic [15:0] act_o;
  logic        act_ps;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Model derives counter position purely from cycles elapsed since reset.
  task automatic step(input string tag);
    exp_t       e;
    logic [7:0] c;
    logic [7:0] dc;
    logic       lvl;
    c = 8'((m_n / CD) % 256);
    if (rst) begin
      e.o  = '0;
      e.ps = 1'b0;
    end else begin
      dc   = SHADOW ? m_shadow : duty;
      lvl  = (dc == 8'hFF) || (c < dc);
      e.o  = en_out & (~en_pwm | {16{lvl}});
      e.ps = (((m_n + 1) % P) == 0);
    end
    e.tag = tag;
    sb.push_back(e);
    if (rst) begin
      m_n      = 0;
      m_shadow = '0;
    end else begin
      if (c == 8'hFF && (m_n % CD) == CD - 1) m_shadow = duty;
      m_n++;
    end
    @(posedge clk);
    #1;
    act_o  = out;
    act_ps = period_start;
    e = sb.pop_front();
    check({e.tag, "/out"}, act_o, e.o);
    check({e.tag, "/period_start"}, act_ps, e.ps);
  endtask

  task automatic wait_ps(input string tag, output int k);
    k = 0;
    do begin
      step(tag);
      k++;
    end while (!act_ps && k <= 2 * P);
    if (!act_ps) timeout({tag, "/wait_ps"});
  endtask

  task automatic count_high(input string tag, input int b, input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      step(tag);
      if (act_o[b]) h++;
    end
  endtask

  task automatic run_to_cnt(input string tag, input int target);
    int k;
    k = 0;
    while (!(((m_n / CD) % 256) == target && (m_n % CD) == 0) && k <= 2 * P) begin
      step(tag);
      k++;
    end
    if (k > 2 * P) timeout({tag, "/run_to_cnt"});
  endtask

  vec_t vecs[5];
  logic [7:0] sweep[4];

  initial begin
    int k;
    int h;
    vecs[0] = '{16'h0000, 16'h0000, 8'h80, 2 * P, "all_off"};
    vecs[1] = '{16'hFFFF, 16'h0000, 8'h80, 3 * P, "all_static_on"};
    vecs[2] = '{16'h00FF, 16'h0001, 8'h40, 2 * P, "bit0_pwm"};
    vecs[3] = '{16'hA5A5, 16'hFF00, 8'h33, P / 2, "mixed"};
    vecs[4] = '{16'h0F0F, 16'hF0F0, 8'hFF, 100, "pwm_without_out"};
    sweep   = '{8'h00, 8'h01, 8'hFE, 8'hFF};

    rst = 1'b1; en_out = '0; en_pwm = '0; duty = 8'h80;
    @(negedge clk);
    step("reset");
    rst = 1'b0;

    wait_ps("first_period", k);
    check("first_ps_latency", k, P);

    foreach (vecs[i]) begin
      en_out = vecs[i].eo;
      en_pwm = vecs[i].ep;
      duty   = vecs[i].d;
      for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].name);
    end

    en_out = 16'h00FF; en_pwm = 16'h0001; duty = 8'h40;
    wait_ps("bit0_align", k);
    count_high("bit0_count", 0, P, h);
    check("bit0_high_clks", h, 64 * CD);
    count_high("bit7_count", 7, P / 4, h);
    check("bit7_static_high", h, P / 4);

    en_out = 16'h8000; en_pwm = 16'h8000;
    foreach (sweep[i]) begin
      duty = sweep[i];
      wait_ps("sweep_align", k);
      count_high("sweep_count", 15, P, h);
      check($sformatf("sweep_%02h_high_clks", sweep[i]), h, (sweep[i] == 8'hFF) ? P : sweep[i] * CD);
    end

    duty = 8'h20;
    wait_ps("dutychg_align", k);
    wait_ps("dutychg_align2", k);
    h = 0;
    for (int c = 0; c < 16'h50 * CD; c++) begin
      step("dutychg_pre");
      if (act_o[15]) h++;
    end
    duty = 8'hC0;
    k = 0;
    do begin
      step("dutychg_post");
      if (act_o[15]) h++;
      k++;
    end while (!act_ps && k <= P);
    if (!act_ps) timeout("dutychg_wait");
    check("dutychg_cur_period", h, SHADOW ? 16'h20 * CD : 16'h90 * CD);
    count_high("dutychg_next", 15, P, h);
    check("dutychg_next_period", h, 16'hC0 * CD);

    en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h80;
    run_to_cnt("midrst_run", 16'h90);
    rst = 1'b1;
    step("midrst");
    check("midrst_out_zero", act_o, 0);
    check("midrst_ps_zero", act_ps, 0);
    rst = 1'b0;
    wait_ps("midrst_release", k);
    check("midrst_first_ps_latency", k, P);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_output_stage.md
Name: pwm_output_stage

Overview:
- Downstream consumer of the SPI register file. Turns its five configuration bytes into 16 registered output pins.
- Inputs: output-enable pair, PWM-enable pair, 8-bit duty cycle.
- Contains a clock prescaler, an 8-bit period counter and a per-bit output mux.
- Sits between the register bank and the chip's output pads (uo_out/uio_out).

Parameters:
- CLK_DIV, 13: system clocks per PWM counter step. Legal range 1..65535. 10 MHz / (13*256) ≈ 3.0 kHz PWM.
- PRESC_W, 16: prescaler counter width; must satisfy 2^PRESC_W ≥ CLK_DIV.

Ports:
- clk  input  1  system clock; sole clock domain.
- rst  input  1  synchronous reset, active-high.
- en_reg_out_7_0  input  8  output enable, bits 7:0.
- en_reg_out_15_8  input  8  output enable, bits 15:8.
- en_reg_pwm_7_0  input  8  PWM mode select, bits 7:0.
- en_reg_pwm_15_8  input  8  PWM mode select, bits 15:8.
- pwm_duty_cycle  input  8  duty; high for duty/256 of the period, 0xFF = always high.
- out  output  16  registered pin drive; out[7:0] maps to the _7_0 registers.
- period_start  output  1  one-clk pulse on the first clk of each PWM period.

Behaviour:
- Reset: one cycle of rst=1 at a clk edge sets all of the following to 0:
  - presc_cnt, pwm_cnt, duty_active
  - out = 16'h0000, period_start = 0
- Reset asserted mid-period: same clearing; the period restarts from pwm_cnt=0 after release.
- Prescaler:
  - presc_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (presc_cnt == CLK_DIV-1), combinational.
  - CLK_DIV=1: tick is high every cycle.
- Period counter:
  - pwm_cnt increments by 1 on tick and wraps 255→0 (natural 8-bit overflow).
  - Period = 256*CLK_DIV clks.
- Period start:
  - period_start is registered and asserted in the cycle after the tick that takes pwm_cnt 255→0.
  - Exactly one clk wide.
  - First period after reset: no pulse; the counter starts at 0 without wrapping.
- Duty source:
  - duty_active is the compare value (see Optional Feature).
- PWM level:
  - pwm_lvl = 1 if duty_active == 8'hFF, else (pwm_cnt < duty_active).
  - duty 0x00 gives constant 0.
  - duty 0x80 gives 128 counts high then 128 counts low.
  - 0xFF is forced fully high: no single-count low glitch.
- Per bit i (0..15), with en_out and en_pwm the concatenated {15_8, 7_0} vectors:
  - out[i] <= en_out[i] ? (en_pwm[i] ? pwm_lvl : 1'b1) : 1'b0
- Latency:
  - out is registered, one clk after its inputs.
  - Enable-register changes reach out in exactly 1 clk, with no period alignment.
- Simultaneous events:
  - duty change coinciding with the wrap tick is taken per Optional Feature.
  - en_pwm without en_out yields 0.
- No handshake with the register bank: inputs are level, quasi-static, already in the clk domain.

Optional Feature:
- Macro: PWM_SHADOW_EN
- Defined:
  - duty_active is a shadow register.
  - It loads pwm_duty_cycle only on the tick where pwm_cnt == 255, so the new duty applies from count 0 of the next period.
  - A mid-period duty write never truncates or extends the current pulse.
  - After reset duty_active=0 until the first wrap, so outputs in PWM mode stay low for the first period.
- Undefined:
  - duty_active is a wire equal to pwm_duty_cycle.
  - Changes affect the compare on the next clk.
  - No shadow flop is synthesised.

Test Plan:
- Reset then all enables 0, duty 0x80, run 2 periods -> out == 16'h0000 throughout; period_start pulses once at 256*CLK_DIV clks after release.
- en_out=16'hFFFF, en_pwm=16'h0000 -> out == 16'hFFFF exactly 1 clk after the enable write; unchanged over 3 periods.
- en_out=16'h00FF, en_pwm=16'h0001, duty 0x40 -> out[0] high 64*CLK_DIV clks per 256*CLK_DIV period (±1 clk); out[7:1]=1; out[15:8]=0.
- Duty sweep 0x00, 0x01, 0xFE, 0xFF on bit 15 (both enables set) -> high counts 0, 1, 254 and 256 (constant high) per period.
- With PWM_SHADOW_EN: duty 0x20→0xC0 written at pwm_cnt=0x50 -> current period high width stays 0x20 counts; next period 0xC0 counts. Without the macro: the pulse rises again immediately, with no 1-clk glitch at the write.
- Assert rst for 1 clk at pwm_cnt=0x90 with outputs active -> next clk out=0, period_start=0; after release the first period_start arrives after exactly 256*CLK_DIV clks.
